// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, boot
// vector, skid entry layout and PC alignment helper.
package riscv_fetch_pkg;

    localparam logic [31:0] FETCH_BOOT_VECTOR = 32'h8000_0000;

    typedef enum logic [1:0] {
        FETCH_ST_IDLE = 2'd0,
        FETCH_ST_RUN  = 2'd1,
        FETCH_ST_WAIT = 2'd2,
        FETCH_ST_DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

    // Branch targets are word aligned; the low two bits are simply dropped.
    function automatic logic [31:0] fetch_align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/riscv_fetch_skid.sv
// One-entry skid buffer holding an (instr, pc, fault) entry that decode could
// not accept in the cycle the cache returned it.
module riscv_fetch_skid
    import riscv_fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush,
    input  logic         in_valid,
    input  fetch_entry_t in_data,
    output logic         out_valid,
    output fetch_entry_t out_data,
    input  logic         out_accept
);

    logic         valid_q;
    fetch_entry_t data_q;

    // A flush wins over everything; a push only happens into an empty slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_valid && !valid_q) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
        end else if (valid_q && out_accept) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch unit: keeps the PC, issues single reads to the icache with
// at most one outstanding, and hands responses to decode through a skid buffer.
module riscv_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_VECTOR = FETCH_BOOT_VECTOR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_fault_o,
    input  logic        fetch_accept_i,
    input  logic        fetch_branch_i,
    input  logic [31:0] fetch_branch_pc_i,
    input  logic        fetch_invalidate_i,
    output logic        icache_rd_o,
    output logic [31:0] icache_pc_o,
    output logic        icache_invalidate_o,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic [31:0] icache_inst_i,
    input  logic        icache_error_i
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc_q;
    logic         inv_prev_q;
    logic         inv_pulse_q;

    logic         resp_take;
    logic         skid_room;
    logic         issue_ok;
    logic         req_fire;
    logic         skid_push;
    logic         skid_valid;
    fetch_entry_t skid_data;
    fetch_entry_t resp_entry;
    fetch_entry_t present;

    // A response is only live in WAIT; a branch in the same cycle kills it.
    assign resp_take = (state_q == FETCH_ST_WAIT) && icache_valid_i && !fetch_branch_i;
    assign skid_room = !skid_valid || fetch_accept_i;

    // In WAIT a new request may only follow a response decode takes at once,
    // which guarantees the skid is free when that request returns.
    always_comb begin
        issue_ok = 1'b0;
        case (state_q)
            FETCH_ST_RUN:  issue_ok = 1'b1;
            FETCH_ST_WAIT: issue_ok = icache_valid_i && fetch_accept_i;
            default:       issue_ok = 1'b0;
        endcase
    end

    assign icache_rd_o = issue_ok && !fetch_branch_i && skid_room;
    assign icache_pc_o = pc_q;
    assign req_fire    = icache_rd_o && icache_accept_i;

    // PC, outstanding-request PC and fetch FSM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= FETCH_ST_IDLE;
            pc_q     <= BOOT_VECTOR;
            req_pc_q <= BOOT_VECTOR;
        end else begin
            if (req_fire) begin
                req_pc_q <= pc_q;
            end
            if (fetch_branch_i) begin
                pc_q <= fetch_align_pc(fetch_branch_pc_i);
            end else if (req_fire) begin
                pc_q <= pc_q + 32'd4;
            end
            case (state_q)
                FETCH_ST_IDLE: state_q <= FETCH_ST_RUN;
                FETCH_ST_RUN: begin
                    if (req_fire) begin
                        state_q <= FETCH_ST_WAIT;
                    end
                end
                FETCH_ST_WAIT: begin
                    if (icache_valid_i) begin
                        state_q <= req_fire ? FETCH_ST_WAIT : FETCH_ST_RUN;
                    end else if (fetch_branch_i) begin
                        state_q <= FETCH_ST_DROP;
                    end
                end
                FETCH_ST_DROP: begin
                    if (icache_valid_i) begin
                        state_q <= FETCH_ST_RUN;
                    end
                end
                default: state_q <= FETCH_ST_IDLE;
            endcase
        end
    end

    assign resp_entry.instr = icache_inst_i;
    assign resp_entry.pc    = req_pc_q;
    assign resp_entry.fault = icache_error_i;
    assign skid_push        = resp_take && !skid_valid && !fetch_accept_i;

    riscv_fetch_skid u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush      (fetch_branch_i),
        .in_valid   (skid_push),
        .in_data    (resp_entry),
        .out_valid  (skid_valid),
        .out_data   (skid_data),
        .out_accept (fetch_accept_i)
    );

    assign present       = skid_valid ? skid_data : resp_entry;
    assign fetch_valid_o = !fetch_branch_i && (skid_valid || resp_take);
    assign fetch_instr_o = present.instr;
    assign fetch_pc_o    = present.pc;
    assign fetch_fault_o = fetch_valid_o && present.fault;

    // Rising edge of the decode-side level becomes a single registered pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inv_prev_q  <= 1'b0;
            inv_pulse_q <= 1'b0;
        end else begin
            inv_prev_q  <= fetch_invalidate_i;
            inv_pulse_q <= fetch_invalidate_i && !inv_prev_q;
        end
    end

    assign icache_invalidate_o = inv_pulse_q;

endmodule

// File: tb/tb_riscv_fetch.sv
// Randomized bench for riscv_fetch against a program-order model of the fetch
// stream and a simple variable-latency icache responder.
module tb_riscv_fetch;

    localparam logic [31:0] BOOT = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid_o;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_fault_o;
    logic        fetch_accept_i;
    logic        fetch_branch_i;
    logic [31:0] fetch_branch_pc_i;
    logic        fetch_invalidate_i;
    logic        icache_rd_o;
    logic [31:0] icache_pc_o;
    logic        icache_invalidate_o;
    logic        icache_accept_i;
    logic        icache_valid_i;
    logic [31:0] icache_inst_i;
    logic        icache_error_i;

    riscv_fetch #(.BOOT_VECTOR(BOOT)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .fetch_valid_o       (fetch_valid_o),
        .fetch_instr_o       (fetch_instr_o),
        .fetch_pc_o          (fetch_pc_o),
        .fetch_fault_o       (fetch_fault_o),
        .fetch_accept_i      (fetch_accept_i),
        .fetch_branch_i      (fetch_branch_i),
        .fetch_branch_pc_i   (fetch_branch_pc_i),
        .fetch_invalidate_i  (fetch_invalidate_i),
        .icache_rd_o         (icache_rd_o),
        .icache_pc_o         (icache_pc_o),
        .icache_invalidate_o (icache_invalidate_o),
        .icache_accept_i     (icache_accept_i),
        .icache_valid_i      (icache_valid_i),
        .icache_inst_i       (icache_inst_i),
        .icache_error_i      (icache_error_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_acc = 0;

    logic [31:0] exp_pc, exp_req, pend_addr;
    logic        pending;
    int          cnt;
    logic        prev_req_hold, prev_show_hold, prev_show_fault;
    logic [31:0] prev_req_pc, prev_show_pc, prev_show_instr;
    logic        inv_d1, inv_d2;
    logic        last_rd, last_valid, last_inv;
    logic [31:0] last_icpc;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00A0_0093;
    endfunction

    function automatic logic memErr(input logic [31:0] a);
        return a[5:2] == 4'hB;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic resetModel();
        exp_pc = BOOT;
        exp_req = BOOT;
        pending = 1'b0;
        pend_addr = '0;
        cnt = 0;
        prev_req_hold = 1'b0;
        prev_show_hold = 1'b0;
        prev_req_pc = '0;
        prev_show_pc = '0;
        prev_show_instr = '0;
        prev_show_fault = 1'b0;
        inv_d1 = 1'b0;
        inv_d2 = 1'b0;
    endtask

    // One clock of stimulus; the model checks everything visible in that cycle.
    task automatic applyStimulus(input logic dec_acc, input logic br, input logic [31:0] br_pc,
                                 input logic c_acc, input int lat, input logic inv);
        @(negedge clk);
        fetch_accept_i = dec_acc;
        fetch_branch_i = br;
        fetch_branch_pc_i = br_pc;
        icache_accept_i = c_acc;
        fetch_invalidate_i = inv;
        icache_valid_i = pending && (cnt == 0);
        icache_inst_i = icache_valid_i ? memWord(pend_addr) : $urandom;
        icache_error_i = icache_valid_i ? memErr(pend_addr) : 1'($urandom_range(0, 1));
        #1;
        last_rd = icache_rd_o;
        last_valid = fetch_valid_o;
        last_inv = icache_invalidate_o;
        last_icpc = icache_pc_o;

        checkOutput("inv_pulse", {31'b0, icache_invalidate_o}, {31'b0, inv_d1 & ~inv_d2});
        checkOutput("one_outstanding", {31'b0, icache_rd_o & pending & ~icache_valid_i}, 32'd0);
        if (prev_req_hold && !br) begin
            checkOutput("req_hold_rd", {31'b0, icache_rd_o}, 32'd1);
            checkOutput("req_hold_pc", icache_pc_o, prev_req_pc);
        end
        if (prev_show_hold && !br) begin
            checkOutput("show_hold_valid", {31'b0, fetch_valid_o}, 32'd1);
            checkOutput("show_hold_pc", fetch_pc_o, prev_show_pc);
            checkOutput("show_hold_instr", fetch_instr_o, prev_show_instr);
            checkOutput("show_hold_fault", {31'b0, fetch_fault_o}, {31'b0, prev_show_fault});
        end
        if (br) begin
            checkOutput("branch_valid", {31'b0, fetch_valid_o}, 32'd0);
            checkOutput("branch_rd", {31'b0, icache_rd_o}, 32'd0);
            exp_pc = br_pc & ~32'h3;
            exp_req = br_pc & ~32'h3;
        end else begin
            if (fetch_valid_o) begin
                checkOutput("fetch_pc", fetch_pc_o, exp_pc);
                checkOutput("fetch_instr", fetch_instr_o, memWord(exp_pc));
                checkOutput("fetch_fault", {31'b0, fetch_fault_o}, {31'b0, memErr(exp_pc)});
                if (dec_acc) begin
                    exp_pc = exp_pc + 32'd4;
                    n_acc++;
                end
            end
            if (icache_rd_o) begin
                checkOutput("icache_pc", icache_pc_o, exp_req);
                if (c_acc) exp_req = exp_req + 32'd4;
            end
        end
        prev_req_hold = icache_rd_o && !c_acc && !br;
        prev_req_pc = icache_pc_o;
        prev_show_hold = fetch_valid_o && !dec_acc && !br;
        prev_show_pc = fetch_pc_o;
        prev_show_instr = fetch_instr_o;
        prev_show_fault = fetch_fault_o;

        if (icache_valid_i) pending = 1'b0;
        else if (pending && cnt > 0) cnt--;
        if (icache_rd_o && c_acc) begin
            pending = 1'b1;
            pend_addr = icache_pc_o;
            cnt = lat;
        end
        inv_d2 = inv_d1;
        inv_d1 = inv;
    endtask

    function automatic logic [31:0] randTarget();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0: t = BOOT + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
            1: t = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            2: t = $urandom;
            default: t = 32'h8000_1003;
        endcase
        return t;
    endfunction

    initial begin
        int pulses;
        logic inv_cur;
        rst = 1'b1;
        fetch_accept_i = 1'b0;
        fetch_branch_i = 1'b0;
        fetch_branch_pc_i = '0;
        fetch_invalidate_i = 1'b0;
        icache_accept_i = 1'b0;
        icache_valid_i = 1'b0;
        icache_inst_i = '0;
        icache_error_i = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", {31'b0, fetch_valid_o}, 32'd0);
        checkOutput("rst_rd", {31'b0, icache_rd_o}, 32'd0);
        checkOutput("rst_inv", {31'b0, icache_invalidate_o}, 32'd0);
        checkOutput("rst_fault", {31'b0, fetch_fault_o}, 32'd0);
        checkOutput("rst_pc", icache_pc_o, BOOT);
        @(posedge clk);
        #2 rst = 1'b0;

        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("idle_no_rd", {31'b0, last_rd}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            checkOutput("stall_rd", {31'b0, last_rd}, 32'd1);
            checkOutput("stall_pc", last_icpc, BOOT);
        end
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 1, 0, 0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0);
            checkOutput("skid_valid", {31'b0, last_valid}, 32'd1);
            checkOutput("skid_no_rd", {31'b0, last_rd}, 32'd0);
        end
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 1, 0, 0);

        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 3, 0);
        applyStimulus(1, 1, 32'h8000_1003, 1, 3, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 1, 0, 0);
        applyStimulus(1, 1, 32'h8000_2002, 1, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 1, 0, 0);

        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 0, 0, 1, 0, (i < 5) ? 1'b1 : 1'b0);
            if (last_inv) pulses++;
        end
        checkOutput("inv_count", pulses, 32'd1);

        inv_cur = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) inv_cur = ~inv_cur;
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, randTarget(),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 3), inv_cur);
        end
        checkOutput("progress", {31'b0, n_acc > 200}, 32'd1);

        applyStimulus(1, 1, 32'h1000_0000, 1, 6, 0);
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1, 0, 0, 1, 6, 0);
            if (pending && cnt >= 2 && cnt <= 5) break;
        end
        checkOutput("reached_wait", {31'b0, pending}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_valid", {31'b0, fetch_valid_o}, 32'd0);
        checkOutput("arst_rd", {31'b0, icache_rd_o}, 32'd0);
        checkOutput("arst_fault", {31'b0, fetch_fault_o}, 32'd0);
        checkOutput("arst_inv", {31'b0, icache_invalidate_o}, 32'd0);
        checkOutput("arst_pc", icache_pc_o, BOOT);
        @(posedge clk);
        #2 rst = 1'b0;
        resetModel();
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("post_rst_idle", {31'b0, last_rd}, 32'd0);
        for (int i = 0; i < 60; i++) begin
            applyStimulus($urandom_range(0, 1), 0, 0, $urandom_range(0, 1), $urandom_range(0, 2), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
